// File: rtl/peak_to_dds_param.sv
// Converts per-frame FFT peak bins into debounced DDS tuning words and waveform selects.
// Each bin is snapped to the STEP_HZ grid by repeated subtraction, then clamped to the legal range.
module peak_to_dds_param #(
  parameter int unsigned BIN_HZ       = 1000,
  parameter int unsigned STEP_HZ      = 5000,
  parameter int unsigned MIN_STEP     = 4,
  parameter int unsigned MAX_STEP     = 20,
  parameter int unsigned FTW_PER_STEP = 214748,
  parameter int unsigned VOTE_N       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done,
  input  logic [1:0]  wave_type,
  input  logic [9:0]  max1_idx,
  input  logic [9:0]  max2_idx,
  output logic        update,
  output logic        busy,
  output logic [31:0] ftw_a,
  output logic [31:0] ftw_b,
  output logic        tri_a,
  output logic        tri_b,
  output logic        params_valid,
  output logic        locked
);

  typedef enum logic [2:0] {IDLE, CAPTURE, DIV_A, DIV_B, VOTE, PUBLISH} state_t;

  localparam logic [23:0] STEP_C = 24'(STEP_HZ);
  localparam logic [23:0] HALF_C = 24'(STEP_HZ / 2);
  localparam logic [23:0] BIN_C  = 24'(BIN_HZ);
  localparam logic [7:0]  MIN_C  = 8'(MIN_STEP);
  localparam logic [7:0]  MAX_C  = 8'(MAX_STEP);
  localparam logic [7:0]  VOTE_C = 8'(VOTE_N);
  localparam logic [31:0] FTW_C  = 32'(FTW_PER_STEP);

  state_t      state, state_next;
  logic        frame_prev;
  logic [9:0]  idx2_q;
  logic [1:0]  type_q;
  logic [23:0] rem;
  logic [7:0]  quo;
  logic [7:0]  step_a, step_b;
  logic [17:0] cand_q, pub_q, candidate;
  logic [7:0]  match_cnt, cnt_next;
  logic        frame_rise, div_more, go;

  function automatic logic [23:0] bin_to_rem(input logic [9:0] idx);
    return {14'd0, idx} * BIN_C + HALF_C;
  endfunction

  function automatic logic [7:0] clamp_step(input logic [7:0] q);
    if (q < MIN_C) return MIN_C;
    if (q > MAX_C) return MAX_C;
    return q;
  endfunction

  assign frame_rise = frame_done && !frame_prev;
  assign div_more   = (rem >= STEP_C);
  assign candidate  = {step_a, step_b, type_q};

  always_comb begin
    cnt_next = 8'd1;
    if (candidate == cand_q)
      cnt_next = (match_cnt >= VOTE_C) ? match_cnt : match_cnt + 8'd1;
    go = (cnt_next >= VOTE_C) && (candidate != pub_q);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_rise) state_next = CAPTURE;
      CAPTURE: state_next = DIV_A;
      DIV_A:   if (!div_more) state_next = DIV_B;
      DIV_B:   if (!div_more) state_next = VOTE;
      VOTE:    state_next = go ? PUBLISH : IDLE;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_prev   <= 1'b0;
      idx2_q       <= '0;
      type_q       <= '0;
      rem          <= '0;
      quo          <= '0;
      step_a       <= '0;
      step_b       <= '0;
      cand_q       <= '0;
      pub_q        <= '0;
      match_cnt    <= '0;
      update       <= 1'b0;
      busy         <= 1'b0;
      ftw_a        <= '0;
      ftw_b        <= '0;
      tri_a        <= 1'b0;
      tri_b        <= 1'b0;
      params_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      // Edge history runs every cycle so a rise during busy is consumed, not queued.
      frame_prev   <= frame_done;
      update       <= 1'b0;
      params_valid <= 1'b0;
      busy         <= (state != IDLE) && (state_next != IDLE);
      unique case (state)
        CAPTURE: begin
          idx2_q <= max2_idx;
          type_q <= wave_type;
          update <= 1'b1;
          rem    <= bin_to_rem(max1_idx);
          quo    <= '0;
        end
        DIV_A, DIV_B: begin
          if (div_more) begin
            rem <= rem - STEP_C;
            if (quo != 8'hFF) quo <= quo + 8'd1;
          end else if (state == DIV_A) begin
            step_a <= clamp_step(quo);
            rem    <= bin_to_rem(idx2_q);
            quo    <= '0;
          end else begin
            step_b <= clamp_step(quo);
          end
        end
        VOTE: begin
          cand_q    <= candidate;
          match_cnt <= cnt_next;
          locked    <= (cnt_next >= VOTE_C);
        end
        PUBLISH: begin
          pub_q        <= candidate;
          ftw_a        <= {24'd0, step_a} * FTW_C;
          ftw_b        <= {24'd0, step_b} * FTW_C;
          tri_a        <= type_q[1];
          tri_b        <= type_q[0];
          params_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_to_dds_param.sv
// Directed bench for peak_to_dds_param: voting, clamping, latency, busy overlap and async reset.
module tb_peak_to_dds_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_done = 1'b0;
  logic [1:0]  wave_type = '0;
  logic [9:0]  max1_idx = '0;
  logic [9:0]  max2_idx = '0;
  logic        update, busy, tri_a, tri_b, params_valid, locked;
  logic [31:0] ftw_a, ftw_b;

  int passed = 0;
  int total  = 0;
  int upd_cnt = 0;
  int pv_cnt  = 0;

  peak_to_dds_param #(
    .BIN_HZ(1000), .STEP_HZ(5000), .MIN_STEP(4), .MAX_STEP(20),
    .FTW_PER_STEP(214748), .VOTE_N(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_done(frame_done), .wave_type(wave_type),
    .max1_idx(max1_idx), .max2_idx(max2_idx), .update(update), .busy(busy),
    .ftw_a(ftw_a), .ftw_b(ftw_b), .tri_a(tri_a), .tri_b(tri_b),
    .params_valid(params_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) upd_cnt++;
    if (params_valid) pv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // lat = edges from the sampling edge to params_valid, or -1 if none.
  task automatic frame(input logic [9:0] a, input logic [9:0] b, input logic [1:0] t,
                       output int lat, output int upd);
    int u0;
    logic done;
    lat = -1;
    done = 1'b0;
    @(negedge clk);
    u0 = upd_cnt;
    max1_idx = a; max2_idx = b; wave_type = t; frame_done = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (params_valid && lat < 0) lat = c - 1;
      if (c > 2 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    frame_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    upd = upd_cnt - u0;
    chk("frame_finished", 32'(done), 32'd1);
  endtask

  initial begin
    int lat, upd, u0, p0;

    #1;
    chk("rst_ftw_a", ftw_a, 0);
    chk("rst_ftw_b", ftw_b, 0);
    chk("rst_outs", {26'd0, tri_a, tri_b, params_valid, update, busy, locked}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single peak at 20 kHz, triangle off
    for (int f = 1; f <= 4; f++) begin
      frame(10'd20, 10'd20, 2'b00, lat, upd);
      chk("t1_update_pulse", 32'(upd), 32'd1);
      if (f < 4) chk("t1_no_pv", 32'(lat), 32'hFFFF_FFFF);
      if (f == 3) chk("t1_unlocked_f3", 32'(locked), 32'd0);
    end
    chk("t1_latency", 32'(lat), 32'd13);
    chk("t1_ftw_a", ftw_a, 32'd858992);
    chk("t1_ftw_b", ftw_b, 32'd858992);
    chk("t1_tri", {30'd0, tri_a, tri_b}, 32'd0);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_pv_pulse", 32'(params_valid), 32'd0);

    // Two peaks 52/81 kHz, A triangle
    for (int f = 1; f <= 4; f++) begin
      frame(10'd52, 10'd81, 2'b10, lat, upd);
      if (f == 1) begin
        chk("t2_lock_drop", 32'(locked), 32'd0);
        chk("t2_ftw_hold", ftw_a, 32'd858992);
      end
    end
    chk("t2_latency", 32'(lat), 32'd31);
    chk("t2_ftw_a", ftw_a, 32'd2147480);
    chk("t2_ftw_b", ftw_b, 32'd3435968);
    chk("t2_tri", {30'd0, tri_a, tri_b}, 32'd2);

    // Clamping to 20 kHz and 100 kHz
    for (int f = 1; f <= 4; f++) begin
      frame(10'd5, 10'd300, 2'b01, lat, upd);
      if (f == 2) chk("t3_ftw_hold", ftw_b, 32'd3435968);
    end
    chk("t3_latency", 32'(lat), 32'd66);
    chk("t3_ftw_a", ftw_a, 32'd858992);
    chk("t3_ftw_b", ftw_b, 32'd4294960);
    chk("t3_tri", {30'd0, tri_a, tri_b}, 32'd1);

    // Debounce: 51 kHz rounds to the same 50 kHz step as 52 kHz
    for (int f = 1; f <= 3; f++) frame(10'd52, 10'd81, 2'b10, lat, upd);
    chk("t4_no_pv_f3", 32'(lat), 32'hFFFF_FFFF);
    frame(10'd51, 10'd81, 2'b10, lat, upd);
    chk("t4_latency", 32'(lat), 32'd31);
    chk("t4_ftw_a", ftw_a, 32'd2147480);
    chk("t4_ftw_b", ftw_b, 32'd3435968);
    frame(10'd60, 10'd81, 2'b10, lat, upd);
    chk("t4_mismatch_no_pv", 32'(lat), 32'hFFFF_FFFF);
    chk("t4_mismatch_unlock", 32'(locked), 32'd0);
    p0 = pv_cnt;
    for (int f = 1; f <= 4; f++) frame(10'd52, 10'd81, 2'b10, lat, upd);
    chk("t4_same_pub_no_pv", 32'(pv_cnt - p0), 32'd0);
    chk("t4_relock", 32'(locked), 32'd1);

    // Busy overlap: second rise 3 cycles in, then a long held level
    @(negedge clk);
    u0 = upd_cnt;
    p0 = pv_cnt;
    max1_idx = 10'd20; max2_idx = 10'd20; wave_type = 2'b00; frame_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd1);
    frame_done = 1'b0;
    @(negedge clk);
    frame_done = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5_overlap_updates", 32'(upd_cnt - u0), 32'd1);
    repeat (2000) @(negedge clk);
    chk("t5_hold_updates", 32'(upd_cnt - u0), 32'd1);
    chk("t5_no_pv", 32'(pv_cnt - p0), 32'd0);
    frame_done = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset in the middle of DIV_B
    p0 = pv_cnt;
    max1_idx = 10'd300; max2_idx = 10'd300; wave_type = 2'b11; frame_done = 1'b1;
    repeat (80) @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ftw_a", ftw_a, 0);
    chk("t6_rst_ftw_b", ftw_b, 0);
    chk("t6_rst_outs", {26'd0, tri_a, tri_b, params_valid, update, busy, locked}, 0);
    frame_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_no_pv_after_rst", 32'(pv_cnt - p0), 32'd0);
    for (int f = 1; f <= 4; f++) begin
      frame(10'd20, 10'd20, 2'b00, lat, upd);
      if (f < 4) chk("t6_fresh_no_pv", 32'(lat), 32'hFFFF_FFFF);
    end
    chk("t6_latency", 32'(lat), 32'd13);
    chk("t6_ftw_a", ftw_a, 32'd858992);
    chk("t6_locked", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
